// File: rtl/jt900h_dumper.sv
// jt900h_dumper: halts a TLCS-900H core and snapshots its register file.
//
// While running, the block watches three trigger sources (fetch address
// reaching a threshold, a watchdog-style timeout, an external request). On a
// trigger it gates the CPU clock enable off, walks dmp_addr over the
// register-file byte addresses and captures the returned bytes into a local
// buffer. The buffer can be read as 32-bit little-endian words at any time.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   ram_addr   CPU fetch address
//   end_addr   address threshold (ram_addr >= end_addr triggers)
//   trig_ext   external dump request (level)
//   rearm      leave DONE and let the CPU run again
//   cen        CPU clock enable
//   dmp_addr   register-file byte address driven to the CPU
//   dmp_din    register-file byte returned by the CPU, LAT cycles later
//   rd_addr    word index into the capture buffer
//   rd_data    captured word, registered one cycle after rd_addr
//   busy       dump or drain in progress
//   done       capture complete, CPU held
//   cause      0 none, 1 address, 2 timeout, 3 external
module jt900h_dumper #(
  parameter  int AW      = 24,
  parameter  int NBYTES  = 80,
  parameter  int LAT     = 1,
  parameter  int TIMEOUT = 100000,
  localparam int RAW     = (NBYTES > 4) ? $clog2(NBYTES / 4) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [AW-1:0]  ram_addr,
  input  logic [AW-1:0]  end_addr,
  input  logic           trig_ext,
  input  logic           rearm,
  output logic           cen,
  output logic [7:0]     dmp_addr,
  input  logic [7:0]     dmp_din,
  input  logic [RAW-1:0] rd_addr,
  output logic [31:0]    rd_data,
  output logic           busy,
  output logic           done,
  output logic [1:0]     cause
);

  localparam int             NWORDS  = NBYTES / 4;
  localparam int             BAW     = RAW + 2;
  localparam int             TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  TO_MAX  = TW'(TIMEOUT);
  localparam logic [7:0]     LAST    = 8'(NBYTES - 1);
  localparam logic [1:0]     LAST_DR = 2'((LAT > 0) ? (LAT - 1) : 0);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DUMP  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [1:0]     cause_q, cause_d;
  logic [7:0]     dmp_addr_q, dmp_addr_d;
  logic [1:0]     drain_q, drain_d;
  logic           cen_q, cen_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [31:0]    rd_data_q, rd_data_d;

  logic           trig_addr;
  logic           trig_to;

  logic [7:0]     buf_q [NBYTES];
  logic           cap_vld;
  logic [BAW-1:0] cap_addr;

  assign trig_addr = (ram_addr >= end_addr);
  assign trig_to   = (TIMEOUT != 0) && (cnt_q == TO_MAX);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    dmp_addr_d = dmp_addr_q;
    drain_d    = drain_q;
    unique case (state_q)
      S_RUN: begin
        if (cnt_q != TO_MAX) cnt_d = cnt_q + TW'(1);
        dmp_addr_d = '0;
        // Priority: address beats timeout beats external
        if (trig_addr) begin
          state_d = S_DUMP;
          cause_d = 2'd1;
        end else if (trig_to) begin
          state_d = S_DUMP;
          cause_d = 2'd2;
        end else if (trig_ext) begin
          state_d = S_DUMP;
          cause_d = 2'd3;
        end
      end
      S_DUMP: begin
        if (dmp_addr_q == LAST) begin
          state_d = (LAT == 0) ? S_DONE : S_DRAIN;
          drain_d = '0;
        end else begin
          dmp_addr_d = dmp_addr_q + 8'd1;
        end
      end
      S_DRAIN: begin
        // dmp_addr holds on the last address while late bytes arrive
        if (drain_q == LAST_DR) state_d = S_DONE;
        else                    drain_d = drain_q + 2'd1;
      end
      S_DONE: begin
        if (rearm) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          cause_d    = '0;
          dmp_addr_d = '0;
        end
      end
      default: state_d = S_RUN;
    endcase
    cen_d  = (state_d == S_RUN);
    busy_d = (state_d == S_DUMP) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Read port: one registered word, zero when the index is past the buffer
  always_comb begin
    rd_data_d = '0;
    if (32'(rd_addr) < NWORDS) begin
      rd_data_d = {buf_q[{rd_addr, 2'd3}], buf_q[{rd_addr, 2'd2}],
                   buf_q[{rd_addr, 2'd1}], buf_q[{rd_addr, 2'd0}]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      cause_q    <= '0;
      dmp_addr_q <= '0;
      drain_q    <= '0;
      cen_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      dmp_addr_q <= dmp_addr_d;
      drain_q    <= drain_d;
      cen_q      <= cen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Capture alignment: the address issued while in DUMP is delayed by LAT
  // cycles so it lines up with the byte the CPU returns for it.
  generate
    if (LAT == 0) begin : g_lat0
      assign cap_vld  = (state_q == S_DUMP);
      assign cap_addr = dmp_addr_q[BAW-1:0];
    end else begin : g_latn
      logic [LAT-1:0] vld_q;
      logic [BAW-1:0] addr_q [LAT];
      always_ff @(posedge clk) begin
        // Clearing the valids on reset drops any byte still in flight
        if (!rst_n) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= (state_q == S_DUMP);
          for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
        addr_q[0] <= dmp_addr_q[BAW-1:0];
        for (int i = 1; i < LAT; i++) addr_q[i] <= addr_q[i-1];
      end
      assign cap_vld  = vld_q[LAT-1];
      assign cap_addr = addr_q[LAT-1];
    end
  endgenerate

  // Capture buffer write
  always_ff @(posedge clk) begin
    if (cap_vld) buf_q[cap_addr] <= dmp_din;
  end

  assign cen      = cen_q;
  assign dmp_addr = dmp_addr_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cause    = cause_q;

endmodule

// File: tb/tb_jt900h_dumper.sv
// Testbench for jt900h_dumper. Three instances: LAT=1/TIMEOUT=50 (inst 0),
// LAT=0/TIMEOUT=0 (inst 1), LAT=2/TIMEOUT=0 (inst 2). Each has a CPU model
// returning dmp_din = dmp_addr ^ key after the instance's latency.
// Directed stimulus pushes time-stamped expectations into a scoreboard queue;
// a monitor on the falling edge pops and compares them.
module tb_jt900h_dumper;

  localparam int SIG_CEN  = 0;
  localparam int SIG_ADDR = 1;
  localparam int SIG_BUSY = 2;
  localparam int SIG_DONE = 3;
  localparam int SIG_CAUS = 4;
  localparam int SIG_RD   = 5;

  logic        clk;
  logic        rst_n;
  logic [23:0] ram_addr;
  logic [23:0] end_addr;
  logic [7:0]  key;

  logic        trig0, trig1, trig2;
  logic        rearm0, rearm1, rearm2;
  logic        cen0, cen1, cen2;
  logic [7:0]  dmp_addr0, dmp_addr1, dmp_addr2;
  logic [7:0]  din0, din1, din2, din2_a;
  logic [4:0]  rd_addr0, rd_addr1, rd_addr2;
  logic [31:0] rd_data0, rd_data1, rd_data2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [1:0]  cause0, cause1, cause2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          inst;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];

  jt900h_dumper #(.AW(24), .NBYTES(80), .LAT(1), .TIMEOUT(50)) u_l1 (
    .clk(clk), .rst_n(rst_n), .ram_addr(ram_addr), .end_addr(end_addr),
    .trig_ext(trig0), .rearm(rearm0), .cen(cen0), .dmp_addr(dmp_addr0),
    .dmp_din(din0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .busy(busy0), .done(done0), .cause(cause0));

  jt900h_dumper #(.AW(24), .NBYTES(80), .LAT(0), .TIMEOUT(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .ram_addr(ram_addr), .end_addr(end_addr),
    .trig_ext(trig1), .rearm(rearm1), .cen(cen1), .dmp_addr(dmp_addr1),
    .dmp_din(din1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .cause(cause1));

  jt900h_dumper #(.AW(24), .NBYTES(80), .LAT(2), .TIMEOUT(0)) u_l2 (
    .clk(clk), .rst_n(rst_n), .ram_addr(ram_addr), .end_addr(end_addr),
    .trig_ext(trig2), .rearm(rearm2), .cen(cen2), .dmp_addr(dmp_addr2),
    .dmp_din(din2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .busy(busy2), .done(done2), .cause(cause2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CPU register-file models with latency 0, 1 and 2
  always_comb din1 = dmp_addr1 ^ key;
  always @(posedge clk) din0 <= dmp_addr0 ^ key;
  always @(posedge clk) begin
    din2_a <= dmp_addr2 ^ key;
    din2   <= din2_a;
  end

  function automatic logic [31:0] act_of(input int inst, input int sig);
    logic [31:0] v [6];
    case (inst)
      0:       v = '{32'(cen0), 32'(dmp_addr0), 32'(busy0), 32'(done0), 32'(cause0), rd_data0};
      1:       v = '{32'(cen1), 32'(dmp_addr1), 32'(busy1), 32'(done1), 32'(cause1), rd_data1};
      default: v = '{32'(cen2), 32'(dmp_addr2), 32'(busy2), 32'(done2), 32'(cause2), rd_data2};
    endcase
    return v[sig];
  endfunction

  task automatic expect_at(input int c, input int inst, input int sig,
                           input logic [31:0] v, input string nm);
    exp_t e;
    int   pos;
    e.cyc = c; e.inst = inst; e.sig = sig; e.exp = v; e.name = nm;
    pos = 0;
    while (pos < sbq.size() && sbq[pos].cyc <= c) pos++;
    sbq.insert(pos, e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input int inst, input int a, input logic [31:0] v, input string nm);
    case (inst)
      0:       rd_addr0 = 5'(a);
      1:       rd_addr1 = 5'(a);
      default: rd_addr2 = 5'(a);
    endcase
    expect_at(cyc + 1, inst, SIG_RD, v, nm);
    tick(1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e   = sbq.pop_front();
      act = act_of(e.inst, e.sig);
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s inst%0d: check for cycle %0d reached at cycle %0d, got %0h required %0h",
                 e.name, e.inst, e.cyc, cyc, act, e.exp);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL %s inst%0d cycle %0d: got %0h required %0h",
                 e.name, e.inst, cyc, act, e.exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int R, Y, Z, W, V;
    rst_n = 1'b0; ram_addr = '0; end_addr = 24'h100; key = 8'h5A;
    trig0 = 0; trig1 = 0; trig2 = 0;
    rearm0 = 0; rearm1 = 0; rearm2 = 0;
    rd_addr0 = '0; rd_addr1 = '0; rd_addr2 = '0;

    // Reset values
    tick(3);
    R = cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_at(R, i, SIG_CEN,  1, "reset_cen");
      expect_at(R, i, SIG_ADDR, 0, "reset_dmp_addr");
      expect_at(R, i, SIG_BUSY, 0, "reset_busy");
      expect_at(R, i, SIG_DONE, 0, "reset_done");
      expect_at(R, i, SIG_CAUS, 0, "reset_cause");
      expect_at(R, i, SIG_RD,   0, "reset_rd_data");
    end

    // Timeout dump on inst 0 (TIMEOUT=50): 51 RUN cycles, then DUMP
    expect_at(R + 50,  0, SIG_CEN,  1,  "to_cen_last_run");
    expect_at(R + 51,  0, SIG_CEN,  0,  "to_cen_dump");
    expect_at(R + 51,  0, SIG_ADDR, 0,  "to_dmp_addr0");
    expect_at(R + 51,  0, SIG_CAUS, 2,  "to_cause");
    expect_at(R + 51,  0, SIG_BUSY, 1,  "to_busy");
    expect_at(R + 130, 0, SIG_ADDR, 79, "to_dmp_addr_last");
    expect_at(R + 131, 0, SIG_BUSY, 1,  "to_busy_drain");
    expect_at(R + 131, 0, SIG_DONE, 0,  "to_done_early");
    expect_at(R + 132, 0, SIG_DONE, 1,  "to_done");
    expect_at(R + 132, 0, SIG_BUSY, 0,  "to_busy_done");
    expect_at(R + 132, 0, SIG_CEN,  0,  "to_cen_done");
    expect_at(R + 130, 1, SIG_CEN,  1,  "noto_cen_l0");
    expect_at(R + 130, 2, SIG_CEN,  1,  "noto_cen_l2");
    tick(136);

    // Buffer contents, key 0x5A
    rd(0, 0,  32'h59585B5A, "rd_w0");
    rd(0, 10, 32'h71707372, "rd_w10");
    rd(0, 19, 32'h15141716, "rd_w19");
    rd(0, 20, 32'h00000000, "rd_oob20");
    rd(0, 31, 32'h00000000, "rd_oob31");

    // Rearm in DONE with trig_ext held: buffer intact, second dump cause 3
    Y = cyc;
    rearm0 = 1; trig0 = 1; key = 8'hA5; rd_addr0 = 5'd0;
    expect_at(Y + 1, 0, SIG_RD,   32'h59585B5A, "rearm_buf_w0");
    expect_at(Y + 1, 0, SIG_CEN,  1, "rearm_cen");
    expect_at(Y + 1, 0, SIG_DONE, 0, "rearm_done");
    expect_at(Y + 1, 0, SIG_CAUS, 0, "rearm_cause");
    expect_at(Y + 2, 0, SIG_CEN,  0, "ext_cen");
    expect_at(Y + 2, 0, SIG_CAUS, 3, "ext_cause");
    expect_at(Y + 2, 0, SIG_ADDR, 0, "ext_dmp_addr0");
    tick(1);
    rearm0 = 0; rd_addr0 = 5'd19;
    expect_at(Y + 2, 0, SIG_RD, 32'h15141716, "rearm_buf_w19");
    tick(1);
    trig0 = 0;
    tick(8);
    rearm0 = 1;
    tick(1);
    rearm0 = 0;
    expect_at(Y + 12, 0, SIG_BUSY, 1,  "busy_rearm_busy");
    expect_at(Y + 12, 0, SIG_ADDR, 10, "busy_rearm_dmp_addr");
    expect_at(Y + 82, 0, SIG_DONE, 0,  "ext_done_early");
    expect_at(Y + 83, 0, SIG_DONE, 1,  "ext_done");
    expect_at(Y + 83, 0, SIG_CAUS, 3,  "ext_cause_hold");
    tick(74);
    rd(0, 0,  32'hA6A7A4A5, "ext_rd_w0");
    rd(0, 19, 32'hEAEBE8E9, "ext_rd_w19");

    // Address + timeout + external together on all instances
    ram_addr = 24'h0FF; key = 8'h5A;
    Z = cyc;
    rearm0 = 1;
    tick(1);
    rearm0 = 0;
    tick(50);
    ram_addr = 24'h100; trig0 = 1; trig1 = 1; trig2 = 1;
    for (int i = 0; i < 3; i++) begin
      expect_at(Z + 51,  i, SIG_CEN,  1,  "addr_cen_run");
      expect_at(Z + 52,  i, SIG_CEN,  0,  "addr_cen_dump");
      expect_at(Z + 52,  i, SIG_ADDR, 0,  "addr_dmp_addr0");
      expect_at(Z + 52,  i, SIG_CAUS, 1,  "addr_cause");
      expect_at(Z + 52,  i, SIG_BUSY, 1,  "addr_busy");
      expect_at(Z + 131, i, SIG_ADDR, 79, "addr_dmp_addr_last");
    end
    expect_at(Z + 132, 0, SIG_DONE, 0, "addr_done_early_l1");
    expect_at(Z + 133, 0, SIG_DONE, 1, "addr_done_l1");
    expect_at(Z + 131, 1, SIG_DONE, 0, "addr_done_early_l0");
    expect_at(Z + 132, 1, SIG_DONE, 1, "addr_done_l0");
    expect_at(Z + 133, 2, SIG_DONE, 0,  "addr_done_early_l2");
    expect_at(Z + 133, 2, SIG_ADDR, 79, "addr_drain_hold_l2");
    expect_at(Z + 133, 2, SIG_BUSY, 1,  "addr_drain_busy_l2");
    expect_at(Z + 134, 2, SIG_DONE, 1,  "addr_done_l2");
    tick(1);
    ram_addr = '0; trig0 = 0; trig1 = 0; trig2 = 0;
    tick(88);
    rd(1, 0,  32'h59585B5A, "l0_rd_w0");
    rd(1, 19, 32'h15141716, "l0_rd_w19");
    rd(1, 20, 32'h00000000, "l0_rd_oob");
    rd(2, 0,  32'h59585B5A, "l2_rd_w0");
    rd(2, 19, 32'h15141716, "l2_rd_w19");
    rd(2, 20, 32'h00000000, "l2_rd_oob");
    rd(0, 0,  32'h59585B5A, "l1_rd_w0");

    // TIMEOUT=0: no trigger for 10000 cycles
    W = cyc;
    rearm1 = 1;
    expect_at(W + 1, 1, SIG_DONE, 0, "nto_done");
    expect_at(W + 1, 1, SIG_CAUS, 0, "nto_cause");
    for (int k = 1; k <= 20; k++) expect_at(W + k * 500, 1, SIG_CEN, 1, "nto_cen");
    tick(1);
    rearm1 = 0;
    tick(10000);

    // Reset in the middle of a dump, then a full clean dump
    key = 8'hFF;
    V = cyc;
    rearm0 = 1; trig0 = 1;
    tick(1);
    rearm0 = 0;
    tick(1);
    trig0 = 0;
    expect_at(V + 2,  0, SIG_CAUS, 3,  "abort_cause");
    expect_at(V + 42, 0, SIG_ADDR, 40, "abort_dmp_addr40");
    tick(40);
    rst_n = 1'b0;
    expect_at(V + 43, 0, SIG_CEN,  1, "abort_cen");
    expect_at(V + 43, 0, SIG_BUSY, 0, "abort_busy");
    expect_at(V + 43, 0, SIG_DONE, 0, "abort_done");
    expect_at(V + 43, 0, SIG_CAUS, 0, "abort_cause_clr");
    expect_at(V + 43, 0, SIG_ADDR, 0, "abort_dmp_addr");
    tick(1);
    rst_n = 1'b1; key = 8'hA5;
    tick(2);
    trig0 = 1;
    tick(1);
    trig0 = 0;
    expect_at(V + 46,  0, SIG_CAUS, 3, "redump_cause");
    expect_at(V + 126, 0, SIG_DONE, 0, "redump_done_early");
    expect_at(V + 127, 0, SIG_DONE, 1, "redump_done");
    tick(84);
    rd(0, 0,  32'hA6A7A4A5, "redump_w0");
    rd(0, 10, 32'h8E8F8C8D, "redump_w10");
    rd(0, 19, 32'hEAEBE8E9, "redump_w19");

    // Let the monitor consume what is left, bounded
    for (int k = 0; k < 10 && sbq.size() > 0; k++) tick(1);
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL %s inst%0d: check for cycle %0d never reached, required %0h",
               e.name, e.inst, e.cyc, e.exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
